updown_counter_scan: RTL and testbench

// - Parametrised up/down counter driven by two push buttons with on-chip sync, debounce and hold-to-repeat.
// - Shows the count in hex on a multiplexed multi-digit 7-segment display.
// - Sits between raw board buttons and display pins; successor of the 3-bit single-digit button counter.

---
 rtl/updown_counter_scan.sv | 237 +++++++++++++++++++++++
 tb/tb_updown_counter_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_scan.sv
// Button-driven up/down counter with synchronise, debounce and hold-to-repeat per button,
// showing the count in hex on a multiplexed 7-segment display.
module updown_counter_scan #(
   parameter int               WIDTH        = 8,
   parameter int               DIGITS       = 2,
   parameter int               WRAP         = 1,
   parameter logic [WIDTH-1:0] MAX_VAL      = {WIDTH{1'b1}},
   parameter int               DEB_CYCLES   = 16,
   parameter int               REPEAT_DELAY = 1000,
   parameter int               REPEAT_RATE  = 200,
   parameter int               SCAN_CYCLES  = 1000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              incr,
   input  logic              decr,
   input  logic              clr,
   output logic [WIDTH-1:0]  value,
   output logic              at_max,
   output logic              at_min,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_sel
);

   localparam int DCW   = $clog2(DEB_CYCLES + 1);
   localparam int TMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW    = $clog2(TMAX + 1);
   localparam int SW    = $clog2(SCAN_CYCLES + 1);
   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      case (nib)
         4'h0: hex_glyph = 7'h3F;
         4'h1: hex_glyph = 7'h06;
         4'h2: hex_glyph = 7'h5B;
         4'h3: hex_glyph = 7'h4F;
         4'h4: hex_glyph = 7'h66;
         4'h5: hex_glyph = 7'h6D;
         4'h6: hex_glyph = 7'h7D;
         4'h7: hex_glyph = 7'h07;
         4'h8: hex_glyph = 7'h7F;
         4'h9: hex_glyph = 7'h6F;
         4'hA: hex_glyph = 7'h77;
         4'hB: hex_glyph = 7'h7C;
         4'hC: hex_glyph = 7'h39;
         4'hD: hex_glyph = 7'h5E;
         4'hE: hex_glyph = 7'h79;
         4'hF: hex_glyph = 7'h71;
         default: hex_glyph = 7'h00;
      endcase
   endfunction

   logic [1:0]       raw_s;
   logic [1:0]       step_s;
   logic [WIDTH-1:0] value_r;
   logic [WIDTH-1:0] value_s;

   assign raw_s = {decr, incr};

   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic           sync1_r, sync2_r, deb_r;
      logic [DCW-1:0] deb_cnt_r;
      state_t         state_r, state_s;
      logic [TW-1:0]  timer_r, timer_s;
      logic           step_r, step_nx_s;

      // Two-flop synchroniser for the asynchronous button
      always_ff @(posedge clock) begin
         if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
         end else begin
            sync1_r <= raw_s[b];
            sync2_r <= sync1_r;
         end
      end

      // Debouncer: accept a new level only after DEB_CYCLES unbroken cycles of disagreement
      always_ff @(posedge clock) begin
         if (!reset) begin
            deb_r     <= 1'b0;
            deb_cnt_r <= {DCW{1'b0}};
         end else if (sync2_r != deb_r) begin
            if (deb_cnt_r == DCW'(DEB_CYCLES - 1)) begin
               deb_r     <= sync2_r;
               deb_cnt_r <= {DCW{1'b0}};
            end else begin
               deb_cnt_r <= deb_cnt_r + DCW'(1);
            end
         end else begin
            deb_cnt_r <= {DCW{1'b0}};
         end
      end

      // Repeat FSM state, timer and registered step pulse
      always_ff @(posedge clock) begin
         if (!reset) begin
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
            step_r  <= 1'b0;
         end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            step_r  <= step_nx_s;
         end
      end

      // Repeat FSM next state; IDLE with a high level only follows a debounced rise
      always_comb begin
         state_s   = state_r;
         timer_s   = timer_r;
         step_nx_s = 1'b0;
         case (state_r)
            ST_IDLE: begin
               timer_s = {TW{1'b0}};
               if (deb_r) begin
                  step_nx_s = 1'b1;
                  state_s   = ST_HELD;
               end else begin
                  state_s   = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (!deb_r) begin
                  state_s = ST_IDLE;
                  timer_s = {TW{1'b0}};
               end else if (timer_r == TW'(REPEAT_DELAY - 1)) begin
                  step_nx_s = 1'b1;
                  state_s   = ST_REPEAT;
                  timer_s   = {TW{1'b0}};
               end else begin
                  timer_s = timer_r + TW'(1);
               end
            end
            ST_REPEAT: begin
               if (!deb_r) begin
                  state_s = ST_IDLE;
                  timer_s = {TW{1'b0}};
               end else if (timer_r == TW'(REPEAT_RATE - 1)) begin
                  step_nx_s = 1'b1;
                  timer_s   = {TW{1'b0}};
               end else begin
                  timer_s = timer_r + TW'(1);
               end
            end
            default: begin
               state_s = ST_IDLE;
               timer_s = {TW{1'b0}};
            end
         endcase
      end

      assign step_s[b] = step_r;
   end

   // Next count: clear beats steps, simultaneous steps cancel
   always_comb begin
      value_s = value_r;
      if (clr) begin
         value_s = {WIDTH{1'b0}};
      end else if (step_s[0] && step_s[1]) begin
         value_s = value_r;
      end else if (step_s[0]) begin
         if (value_r == MAX_VAL) begin
            value_s = (WRAP != 0) ? {WIDTH{1'b0}} : MAX_VAL;
         end else begin
            value_s = value_r + WIDTH'(1);
         end
      end else if (step_s[1]) begin
         if (value_r == {WIDTH{1'b0}}) begin
            value_s = (WRAP != 0) ? MAX_VAL : {WIDTH{1'b0}};
         end else begin
            value_s = value_r - WIDTH'(1);
         end
      end else begin
         value_s = value_r;
      end
   end

   // Count register
   always_ff @(posedge clock) begin
      if (!reset) begin
         value_r <= {WIDTH{1'b0}};
      end else begin
         value_r <= value_s;
      end
   end

   assign value  = value_r;
   assign at_max = (value_r == MAX_VAL);
   assign at_min = (value_r == {WIDTH{1'b0}});

   logic [SW-1:0]         scan_cnt_r;
   logic [IW-1:0]         idx_r, idx_s;
   logic [4*DIGITS-1:0]   padded_s;
   logic [3:0]            nibble_s;
   logic [6:0]            seg_r;
   logic [DIGITS-1:0]     dig_sel_r;

   // Digit index for the coming cycle; seg and dig_sel both follow it so they switch together
   always_comb begin
      idx_s = idx_r;
      if (scan_cnt_r == SW'(SCAN_CYCLES - 1)) begin
         idx_s = (idx_r == IW'(DIGITS - 1)) ? IW'(0) : idx_r + IW'(1);
      end else begin
         idx_s = idx_r;
      end
   end

   assign padded_s = (4*DIGITS)'(value_r);
   assign nibble_s = padded_s[4*idx_s +: 4];

   // Scan timer and registered display outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         scan_cnt_r <= {SW{1'b0}};
         idx_r      <= {IW{1'b0}};
         seg_r      <= 7'h3F;
         dig_sel_r  <= ~(DIGITS'(1));
      end else begin
         scan_cnt_r <= (scan_cnt_r == SW'(SCAN_CYCLES - 1)) ? {SW{1'b0}} : scan_cnt_r + SW'(1);
         idx_r      <= idx_s;
         seg_r      <= hex_glyph(nibble_s);
         dig_sel_r  <= ~(DIGITS'(1) << idx_s);
      end
   end

   assign seg     = seg_r;
   assign dig_sel = dig_sel_r;

endmodule

// File: tb/tb_updown_counter_scan.sv
// Scoreboard bench for updown_counter_scan: one wrapping and one saturating instance, each
// with an expected-value queue popped by a monitor whenever the count changes.
module tb_updown_counter_scan;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic w_incr = 1'b0, w_decr = 1'b0, w_clr = 1'b0;
   logic s_incr = 1'b0, s_decr = 1'b0, s_clr = 1'b0;
   logic [3:0] w_value, s_value, w_prev, s_prev;
   logic w_at_max, w_at_min, s_at_max, s_at_min;
   logic [6:0] w_seg, s_seg;
   logic [0:0] w_dig_sel, s_dig_sel;
   logic mon_en = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_w[$];
   int exp_s[$];

   always #5 clock = ~clock;

   updown_counter_scan #(.WIDTH(4), .DIGITS(1), .WRAP(1), .MAX_VAL(4'd9), .DEB_CYCLES(4),
      .REPEAT_DELAY(20), .REPEAT_RATE(5), .SCAN_CYCLES(3)) u_wrap (
      .clock(clock), .reset(reset), .incr(w_incr), .decr(w_decr), .clr(w_clr),
      .value(w_value), .at_max(w_at_max), .at_min(w_at_min), .seg(w_seg), .dig_sel(w_dig_sel));

   updown_counter_scan #(.WIDTH(4), .DIGITS(1), .WRAP(0), .MAX_VAL(4'd9), .DEB_CYCLES(4),
      .REPEAT_DELAY(20), .REPEAT_RATE(5), .SCAN_CYCLES(3)) u_sat (
      .clock(clock), .reset(reset), .incr(s_incr), .decr(s_decr), .clr(s_clr),
      .value(s_value), .at_max(s_at_max), .at_min(s_at_min), .seg(s_seg), .dig_sel(s_dig_sel));

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Monitors: every change of a count is matched against the next queued expectation
   always @(negedge clock) begin
      if (mon_en && (w_value !== w_prev)) begin
         if (exp_w.size() == 0) begin
            n_checks++;
            $display("FAIL w_unexpected_change: got %0d expected no change from %0d", w_value, w_prev);
         end else begin
            int e;
            e = exp_w.pop_front();
            check("w_value", int'(w_value), e);
            check("w_at_max", int'(w_at_max), int'(e == 9));
            check("w_at_min", int'(w_at_min), int'(e == 0));
         end
      end
      w_prev <= w_value;
   end

   always @(negedge clock) begin
      if (mon_en && (s_value !== s_prev)) begin
         if (exp_s.size() == 0) begin
            n_checks++;
            $display("FAIL s_unexpected_change: got %0d expected no change from %0d", s_value, s_prev);
         end else begin
            int e;
            e = exp_s.pop_front();
            check("s_value", int'(s_value), e);
            check("s_at_max", int'(s_at_max), int'(e == 9));
            check("s_at_min", int'(s_at_min), int'(e == 0));
         end
      end
      s_prev <= s_value;
   end

   // Hold the chosen buttons for 'hold' sampling edges, then idle long enough to settle
   task automatic press(input bit sat, input bit up, input bit dn, input int hold);
      @(negedge clock);
      if (sat) begin s_incr = up; s_decr = dn; end
      else begin w_incr = up; w_decr = dn; end
      repeat (hold) @(negedge clock);
      w_incr = 1'b0; w_decr = 1'b0; s_incr = 1'b0; s_decr = 1'b0;
      repeat (20) @(negedge clock);
   endtask

   initial begin
      int cnt;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rst_value", int'(w_value), 0);
      check("rst_at_min", int'(w_at_min), 1);
      check("rst_at_max", int'(w_at_max), 0);
      check("rst_seg", int'(w_seg), 7'b0111111);
      check("rst_dig_sel", int'(w_dig_sel), 0);
      mon_en = 1'b1;

      // Latency: edges from first sampling of incr until the count moves
      exp_w.push_back(1);
      @(negedge clock);
      w_incr = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock);
         #1;
         if (w_value == 4'd1) break;
         cnt++;
      end
      check("latency_edges", cnt, 7);
      repeat (3) @(negedge clock);
      w_incr = 1'b0;
      repeat (30) @(negedge clock);
      check("short_press_no_repeat", int'(w_value), 1);
      check("seg_one", int'(w_seg), 7'b0000110);

      // Hold 58 sampling edges: press step plus 8 repeats (delay 20, rate 5), wrapping 9->0
      for (int v = 2; v <= 9; v++) exp_w.push_back(v);
      exp_w.push_back(0);
      press(1'b0, 1'b1, 1'b0, 58);
      check("after_hold", int'(w_value), 0);

      // Bouncing every 2 cycles never stays stable for 4
      @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         w_incr = (i % 2 == 0);
         repeat (2) @(negedge clock);
      end
      w_incr = 1'b0;
      repeat (20) @(negedge clock);
      check("bounce_no_step", int'(w_value), 0);

      press(1'b0, 1'b1, 1'b1, 8);
      check("both_no_change", int'(w_value), 0);

      for (int v = 1; v <= 5; v++) begin
         exp_w.push_back(v);
         press(1'b0, 1'b1, 1'b0, 8);
      end
      check("seg_five", int'(w_seg), 7'b1101101);

      // clr raised for exactly the edge that would apply the inc step
      exp_w.push_back(0);
      @(negedge clock);
      w_incr = 1'b1;
      repeat (7) @(negedge clock);
      w_clr = 1'b1;
      @(negedge clock);
      w_clr = 1'b0;
      w_incr = 1'b0;
      repeat (20) @(negedge clock);
      check("clr_beats_step", int'(w_value), 0);

      // Reset during REPEAT (after steps to 1, 2, 3); button released during reset
      exp_w.push_back(1); exp_w.push_back(2); exp_w.push_back(3); exp_w.push_back(0);
      @(negedge clock);
      w_incr = 1'b1;
      repeat (34) @(negedge clock);
      reset = 1'b0;
      w_incr = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (30) @(negedge clock);
      check("no_step_after_reset", int'(w_value), 0);
      exp_w.push_back(1);
      press(1'b0, 1'b1, 1'b0, 8);
      check("repress_after_reset", int'(w_value), 1);

      // Saturating instance: floor at 0, ceiling at 9
      press(1'b1, 1'b0, 1'b1, 8);
      check("sat_floor", int'(s_value), 0);
      for (int v = 1; v <= 9; v++) begin
         exp_s.push_back(v);
         press(1'b1, 1'b1, 1'b0, 8);
      end
      press(1'b1, 1'b1, 1'b0, 8);
      check("sat_ceiling", int'(s_value), 9);
      check("sat_at_max", int'(s_at_max), 1);

      check("w_queue_left", exp_w.size(), 0);
      check("s_queue_left", exp_s.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
